axi_write_txn_ctrl: RTL and testbench

Write-channel transaction controller for the AXI interconnect. It arbitrates AW requests from masters M0–M2 round-robin and decodes the winning address to a slave index. It then holds that master→slave grant across the AW, W and B phases until the B handshake completes, with a watchdog that releases a hung transaction. The crossbar muxes use its registered grant outputs, so no master can steal a path mid-burst.

---
 rtl/bus_map_pkg.sv | 43 ++++
 rtl/bus_addr_decode.sv | 35 +++
 rtl/axi_write_txn_ctrl.sv | 168 ++++++++++++++++
 tb/tb_axi_write_txn_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// Shared bus map for the AXI interconnect: slave indices,
// region bases and write-controller state encoding.
package bus_map_pkg;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    localparam logic [15:0] BASE_ROM   = 16'h0000;
    localparam logic [15:0] BASE_IM    = 16'h0001;
    localparam logic [15:0] BASE_DM    = 16'h0002;
    localparam logic [15:0] BASE_SCTRL = 16'h1000;
    localparam logic [15:0] BASE_WDT   = 16'h1001;
    localparam logic [15:0] BASE_EPU   = 16'h0010;
    localparam logic [15:0] BASE_DMA   = 16'h0003;
    localparam logic [7:0]  BASE_DRAM  = 8'h20;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    // Lowest offset from last winner takes priority.
    function automatic logic [1:0] rr_pick(
        input logic [2:0] req,
        input logic [1:0] last
    );
        logic [1:0] pick;
        logic [1:0] idx;
        pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % 3);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder shared by the read and
// write transaction controllers.
import bus_map_pkg::*;

module bus_addr_decode (
    input  logic [31:0] addr_i,
    output logic [2:0]  slave_sel_o,
    output logic        decerr_o
);

    logic unused_lo;
    assign unused_lo = ^addr_i[15:0];

    always_comb begin
        slave_sel_o = S0;
        decerr_o    = 1'b0;
        unique case (addr_i[31:16])
            BASE_ROM:   slave_sel_o = S0;
            BASE_IM:    slave_sel_o = S1;
            BASE_DM:    slave_sel_o = S2;
            BASE_SCTRL: slave_sel_o = S3;
            BASE_WDT:   slave_sel_o = S4;
            BASE_EPU:   slave_sel_o = S6;
            BASE_DMA:   slave_sel_o = S7;
            default: begin
                if (addr_i[31:24] == BASE_DRAM) begin
                    slave_sel_o = S5;
                end else begin
                    decerr_o = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/axi_write_txn_ctrl.sv
// AXI write-channel grant controller: round-robin AW arbitration,
// grant held through AW/W/B, watchdog release of hung paths.
import bus_map_pkg::*;

module axi_write_txn_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        AWVALID_M0,
    input  logic        AWVALID_M1,
    input  logic        AWVALID_M2,
    input  logic [31:0] AWADDR_M0,
    input  logic [31:0] AWADDR_M1,
    input  logic [31:0] AWADDR_M2,
    input  logic        AWREADY_SEL,
    input  logic        WVALID_SEL,
    input  logic        WREADY_SEL,
    input  logic        WLAST_SEL,
    input  logic        BVALID_SEL,
    input  logic        BREADY_SEL,
    output logic        grant_valid,
    output logic [2:0]  grant_m,
    output logic [2:0]  slave_sel,
    output logic        decerr,
    output logic        timeout_err
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       owner_q, owner_d;
    logic [2:0]       grant_m_q, grant_m_d;
    logic             gvalid_q, gvalid_d;
    logic [2:0]       slave_q, slave_d;
    logic             decerr_q, decerr_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]  aw_req;
    logic [1:0]  win;
    logic [31:0] win_addr;
    logic [2:0]  dec_sel;
    logic        dec_err;
    logic        owner_awv;
    logic        aw_hs;
    logic        wlast_hs;
    logic        b_hs;
    logic        wd_exp;

    assign aw_req = {AWVALID_M2, AWVALID_M1, AWVALID_M0};
    assign win    = rr_pick(aw_req, last_q);

    always_comb begin
        unique case (win)
            2'd0:    win_addr = AWADDR_M0;
            2'd1:    win_addr = AWADDR_M1;
            default: win_addr = AWADDR_M2;
        endcase
    end

    bus_addr_decode u_dec (
        .addr_i      (win_addr),
        .slave_sel_o (dec_sel),
        .decerr_o    (dec_err)
    );

    always_comb begin
        unique case (owner_q)
            2'd0:    owner_awv = AWVALID_M0;
            2'd1:    owner_awv = AWVALID_M1;
            default: owner_awv = AWVALID_M2;
        endcase
    end

    assign aw_hs    = owner_awv && AWREADY_SEL;
    assign wlast_hs = WVALID_SEL && WREADY_SEL && WLAST_SEL;
    assign b_hs     = BVALID_SEL && BREADY_SEL;
    assign wd_exp   = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        grant_m_d = grant_m_q;
        gvalid_d  = gvalid_q;
        slave_d   = slave_q;
        decerr_d  = decerr_q;
        tout_d    = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|aw_req) begin
                    state_d   = ST_AW;
                    owner_d   = win;
                    grant_m_d = 3'b001 << win;
                    gvalid_d  = 1'b1;
                    slave_d   = dec_sel;
                    decerr_d  = dec_err;
                end
            end
            ST_AW: begin
                cnt_d = '0;
                if (aw_hs) state_d = wlast_hs ? ST_B : ST_W;
            end
            ST_W: begin
                cnt_d = cnt_q + 1'b1;
                if (wd_exp) begin
                    state_d = ST_IDLE;
                    tout_d  = 1'b1;
                end else if (wlast_hs) begin
                    state_d = ST_B;
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (b_hs) begin
                    state_d = ST_IDLE;
                end else if (wd_exp) begin
                    state_d = ST_IDLE;
                    tout_d  = 1'b1;
                end
            end
        endcase
        // Any exit from W/B releases the path and moves the pointer.
        if (state_q[1] && state_d == ST_IDLE) begin
            last_d    = owner_q;
            owner_d   = 2'd0;
            grant_m_d = 3'b000;
            gvalid_d  = 1'b0;
            slave_d   = S0;
            decerr_d  = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'd2;
            owner_q   <= 2'd0;
            grant_m_q <= 3'b000;
            gvalid_q  <= 1'b0;
            slave_q   <= S0;
            decerr_q  <= 1'b0;
            tout_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            grant_m_q <= grant_m_d;
            gvalid_q  <= gvalid_d;
            slave_q   <= slave_d;
            decerr_q  <= decerr_d;
            tout_q    <= tout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant_valid = gvalid_q;
    assign grant_m     = grant_m_q;
    assign slave_sel   = slave_q;
    assign decerr      = decerr_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_axi_write_txn_ctrl.sv
// Directed bench for axi_write_txn_ctrl with a short watchdog.
module tb_axi_write_txn_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        AWVALID_M0, AWVALID_M1, AWVALID_M2;
    logic [31:0] AWADDR_M0, AWADDR_M1, AWADDR_M2;
    logic        AWREADY_SEL;
    logic        WVALID_SEL, WREADY_SEL, WLAST_SEL;
    logic        BVALID_SEL, BREADY_SEL;
    logic        grant_valid;
    logic [2:0]  grant_m;
    logic [2:0]  slave_sel;
    logic        decerr;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    axi_write_txn_ctrl #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .AWVALID_M0  (AWVALID_M0),
        .AWVALID_M1  (AWVALID_M1),
        .AWVALID_M2  (AWVALID_M2),
        .AWADDR_M0   (AWADDR_M0),
        .AWADDR_M1   (AWADDR_M1),
        .AWADDR_M2   (AWADDR_M2),
        .AWREADY_SEL (AWREADY_SEL),
        .WVALID_SEL  (WVALID_SEL),
        .WREADY_SEL  (WREADY_SEL),
        .WLAST_SEL   (WLAST_SEL),
        .BVALID_SEL  (BVALID_SEL),
        .BREADY_SEL  (BREADY_SEL),
        .grant_valid (grant_valid),
        .grant_m     (grant_m),
        .slave_sel   (slave_sel),
        .decerr      (decerr),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic quiet();
        AWVALID_M0 = 0; AWVALID_M1 = 0; AWVALID_M2 = 0;
        AWREADY_SEL = 0;
        WVALID_SEL = 0; WREADY_SEL = 0; WLAST_SEL = 0;
        BVALID_SEL = 0; BREADY_SEL = 0;
    endtask

    task automatic set_w(input logic v, input logic last);
        WVALID_SEL = v; WREADY_SEL = v; WLAST_SEL = last;
    endtask

    task automatic set_b(input logic v);
        BVALID_SEL = v; BREADY_SEL = v;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_gv"}, 32'(grant_valid), 0);
        check({tag, "_gm"}, 32'(grant_m), 0);
        check({tag, "_ss"}, 32'(slave_sel), 0);
        check({tag, "_de"}, 32'(decerr), 0);
        check({tag, "_to"}, 32'(timeout_err), 0);
    endtask

    task automatic do_reset();
        ARESETn = 0;
        quiet();
        step();
        ARESETn = 1;
    endtask

    logic [2:0] rr_exp [4];
    logic [2:0] rr_ss  [4];

    initial begin
        AWADDR_M0 = 0; AWADDR_M1 = 0; AWADDR_M2 = 0;
        ARESETn = 0;
        quiet();
        step();
        step();
        chk_idle("rst");
        ARESETn = 1;

        // Basic 4-beat write from M1 to DM
        AWVALID_M1 = 1; AWADDR_M1 = 32'h0002_0040;
        step();
        check("t1_gv", 32'(grant_valid), 1);
        check("t1_gm", 32'(grant_m), 3'b010);
        check("t1_ss", 32'(slave_sel), 2);
        check("t1_de", 32'(decerr), 0);
        AWREADY_SEL = 1;
        step();
        AWVALID_M1 = 0; AWREADY_SEL = 0;
        set_w(1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_wbeat_gm", 32'(grant_m), 3'b010);
        end
        set_w(1, 1);
        step();
        set_w(0, 0);
        check("t1_b_gm", 32'(grant_m), 3'b010);
        step();
        check("t1_b_hold", 32'(grant_valid), 1);
        set_b(1);
        step();
        set_b(0);
        chk_idle("t1_rel");

        // Round-robin with everything held high
        do_reset();
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0100;
        AWVALID_M1 = 1; AWADDR_M1 = 32'h1000_0000;
        AWVALID_M2 = 1; AWADDR_M2 = 32'h2000_1234;
        AWREADY_SEL = 1;
        set_w(1, 1);
        set_b(1);
        rr_exp[0] = 3'b001; rr_ss[0] = 3'd0;
        rr_exp[1] = 3'b010; rr_ss[1] = 3'd3;
        rr_exp[2] = 3'b100; rr_ss[2] = 3'd5;
        rr_exp[3] = 3'b001; rr_ss[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_gm", 32'(grant_m), 32'(rr_exp[i]));
            check("t2_ss", 32'(slave_sel), 32'(rr_ss[i]));
            step();
            check("t2_inB", 32'(grant_m), 32'(rr_exp[i]));
            step();
            check("t2_gap", 32'(grant_valid), 0);
        end
        quiet();

        // Unmapped address from M0
        AWVALID_M0 = 1; AWADDR_M0 = 32'h3000_0000;
        step();
        check("t3_gm", 32'(grant_m), 3'b001);
        check("t3_de", 32'(decerr), 1);
        check("t3_ss", 32'(slave_sel), 0);
        AWREADY_SEL = 1;
        step();
        quiet();
        set_w(1, 1);
        step();
        set_w(0, 0);
        check("t3_inB_de", 32'(decerr), 1);
        set_b(1);
        step();
        set_b(0);
        chk_idle("t3_rel");

        // Coincident AW and WLAST handshake, M2 to DMA
        AWVALID_M2 = 1; AWADDR_M2 = 32'h0003_0000;
        step();
        check("t4_gm", 32'(grant_m), 3'b100);
        check("t4_ss", 32'(slave_sel), 7);
        AWREADY_SEL = 1;
        set_w(1, 1);
        step();
        quiet();
        check("t4_held", 32'(grant_valid), 1);
        set_b(1);
        step();
        set_b(0);
        check("t4_rel", 32'(grant_valid), 0);

        // Watchdog: WLAST accepted, BVALID never comes
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0001_0000;
        step();
        check("t5_gm", 32'(grant_m), 3'b001);
        check("t5_ss", 32'(slave_sel), 1);
        AWREADY_SEL = 1;
        step();
        quiet();
        set_w(1, 1);
        step();
        set_w(0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_quiet", 32'(timeout_err), 0);
            check("t5_hold", 32'(grant_valid), 1);
        end
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0000;
        AWVALID_M1 = 1; AWADDR_M1 = 32'h1001_0000;
        step();
        check("t5_to", 32'(timeout_err), 1);
        check("t5_to_gv", 32'(grant_valid), 0);
        step();
        check("t5_pulse", 32'(timeout_err), 0);
        check("t5_next_gm", 32'(grant_m), 3'b010);
        check("t5_next_ss", 32'(slave_sel), 4);

        // Reset in W with M2 owning
        do_reset();
        AWVALID_M2 = 1; AWADDR_M2 = 32'h0010_0000;
        step();
        check("t6_gm", 32'(grant_m), 3'b100);
        check("t6_ss", 32'(slave_sel), 6);
        AWREADY_SEL = 1;
        step();
        ARESETn = 0;
        quiet();
        step();
        chk_idle("t6_rst");
        ARESETn = 1;
        AWVALID_M0 = 1; AWVALID_M1 = 1; AWVALID_M2 = 1;
        step();
        check("t6_first", 32'(grant_m), 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
